// File: rtl/maze_pkg.sv
// Shared geometry, level encodings, per-level bounds and FSM states for the maze map writer.
package maze_pkg;

    localparam int COLS  = 40;
    localparam int ROWS  = 30;
    localparam int MAP_W = COLS * ROWS;

    localparam int X_W = 6;
    localparam int Y_W = 5;

    localparam logic [1:0] LV_EASY   = 2'b00;
    localparam logic [1:0] LV_NORMAL = 2'b01;
    localparam logic [1:0] LV_HARD   = 2'b10;

    // Exclusive upper bounds on x/y for each difficulty level
    localparam logic [X_W-1:0] EASY_COLS   = 6'd16;
    localparam logic [Y_W-1:0] EASY_ROWS   = 5'd12;
    localparam logic [X_W-1:0] NORMAL_COLS = 6'd32;
    localparam logic [Y_W-1:0] NORMAL_ROWS = 5'd24;
    localparam logic [X_W-1:0] HARD_COLS   = 6'd40;
    localparam logic [Y_W-1:0] HARD_ROWS   = 5'd30;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CLEAR     = 2'd1,
        ST_WAIT_SWAP = 2'd2
    } state_t;

endpackage

// File: rtl/maze_map_writer_if.sv
// Cell-write handshake between a maze generator (master) and the map writer (slave).
interface maze_map_writer_if;
    import maze_pkg::*;

    logic           i_WrValid;
    logic           o_WrReady;
    logic [X_W-1:0] i_WrX;
    logic [Y_W-1:0] i_WrY;
    logic           i_WrWall;

    modport master (
        output i_WrValid,
        output i_WrX,
        output i_WrY,
        output i_WrWall,
        input  o_WrReady
    );

    modport slave (
        input  i_WrValid,
        input  i_WrX,
        input  i_WrY,
        input  i_WrWall,
        output o_WrReady
    );

endinterface

// File: rtl/maze_bounds_check.sv
// Combinational check that a cell coordinate lies inside the playfield of the given level.
module maze_bounds_check
    import maze_pkg::*;
(
    input  logic [1:0]     i_Level,
    input  logic [X_W-1:0] i_X,
    input  logic [Y_W-1:0] i_Y,
    output logic           o_InRange
);

    always_comb begin
        o_InRange = 1'b0;
        case (i_Level)
            LV_EASY:   o_InRange = (i_X < EASY_COLS)   && (i_Y < EASY_ROWS);
            LV_NORMAL: o_InRange = (i_X < NORMAL_COLS) && (i_Y < NORMAL_ROWS);
            LV_HARD:   o_InRange = (i_X < HARD_COLS)   && (i_Y < HARD_ROWS);
            default:   o_InRange = 1'b0;
        endcase
    end

endmodule

// File: rtl/maze_map_writer.sv
// Write-side owner of the maze bitmap: bounded cell writes, row-per-cycle clear, and publish.
// Define MAZE_DOUBLE_BUFFER_EN for a separate display buffer swapped at end of frame.
module maze_map_writer #(
    parameter int COLS = maze_pkg::COLS,
    parameter int ROWS = maze_pkg::ROWS
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic [1:0]           i_MazeLevel,
    input  logic                 i_Clear,
    maze_map_writer_if.slave     wr,
    input  logic                 i_Commit,
    input  logic                 i_FrameDone,
    output logic [COLS*ROWS-1:0] o_MazeMap,
    output logic                 o_Busy,
    output logic                 o_Err,
    output logic                 o_CommitDone
);
    import maze_pkg::*;

    localparam int MAP_BITS = COLS * ROWS;
    localparam int AW       = $clog2(MAP_BITS);

    state_t                state_q, state_d;
    logic [Y_W-1:0]        row_q, row_d;
    logic [MAP_BITS-1:0]   work_q, work_d;
    logic                  err_q, err_d;
    logic                  commit_done_q, commit_done_d;
`ifdef MAZE_DOUBLE_BUFFER_EN
    logic [MAP_BITS-1:0]   disp_q, disp_d;
`else
    logic                  frame_done_unused;
    assign frame_done_unused = i_FrameDone;
`endif

    logic          in_range;
    logic          wr_fire;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] row_base;

    maze_bounds_check u_bounds (
        .i_Level   (i_MazeLevel),
        .i_X       (wr.i_WrX),
        .i_Y       (wr.i_WrY),
        .o_InRange (in_range)
    );

    // Clear and commit take priority, so they also stall the write handshake
    assign wr.o_WrReady = (state_q == ST_IDLE) & ~i_Clear & ~i_Commit;
    assign wr_fire      = wr.i_WrValid & wr.o_WrReady;
    assign wr_idx       = AW'(wr.i_WrY) * AW'(COLS) + AW'(wr.i_WrX);
    assign row_base     = AW'(row_q) * AW'(COLS);

    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        work_d        = work_q;
        err_d         = err_q;
        commit_done_d = 1'b0;
`ifdef MAZE_DOUBLE_BUFFER_EN
        disp_d        = disp_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_Clear) begin
                    state_d = ST_CLEAR;
                    row_d   = '0;
                    err_d   = 1'b0;
                end else if (i_Commit) begin
`ifdef MAZE_DOUBLE_BUFFER_EN
                    state_d = ST_WAIT_SWAP;
`else
                    commit_done_d = 1'b1;
`endif
                end else if (wr_fire) begin
                    if (in_range) begin
                        work_d[wr_idx] = wr.i_WrWall;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                work_d[row_base +: COLS] = '0;
                if (row_q == Y_W'(ROWS - 1)) begin
                    state_d = ST_IDLE;
                    row_d   = '0;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
            ST_WAIT_SWAP: begin
`ifdef MAZE_DOUBLE_BUFFER_EN
                if (i_FrameDone) begin
                    disp_d        = work_q;
                    commit_done_d = 1'b1;
                    state_d       = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state_q       <= ST_IDLE;
            row_q         <= '0;
            work_q        <= '0;
            err_q         <= 1'b0;
            commit_done_q <= 1'b0;
`ifdef MAZE_DOUBLE_BUFFER_EN
            disp_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            work_q        <= work_d;
            err_q         <= err_d;
            commit_done_q <= commit_done_d;
`ifdef MAZE_DOUBLE_BUFFER_EN
            disp_q        <= disp_d;
`endif
        end
    end

`ifdef MAZE_DOUBLE_BUFFER_EN
    assign o_MazeMap = disp_q;
`else
    assign o_MazeMap = work_q;
`endif
    assign o_Busy       = (state_q == ST_CLEAR) | (state_q == ST_WAIT_SWAP);
    assign o_Err        = err_q;
    assign o_CommitDone = commit_done_q;

endmodule

// File: tb/tb_maze_map_writer.sv
// Directed bench for maze_map_writer; follows MAZE_DOUBLE_BUFFER_EN for the publish flow.
module tb_maze_map_writer;
    import maze_pkg::*;

    logic          i_Clk = 1'b0;
    logic          i_Rst = 1'b0;
    logic [1:0]    i_MazeLevel = LV_EASY;
    logic          i_Clear = 1'b0;
    logic          i_Commit = 1'b0;
    logic          i_FrameDone = 1'b0;
    logic [1199:0] o_MazeMap;
    logic          o_Busy;
    logic          o_Err;
    logic          o_CommitDone;

    maze_map_writer_if wr ();

    maze_map_writer #(.COLS(40), .ROWS(30)) dut (
        .i_Clk        (i_Clk),
        .i_Rst        (i_Rst),
        .i_MazeLevel  (i_MazeLevel),
        .i_Clear      (i_Clear),
        .wr           (wr),
        .i_Commit     (i_Commit),
        .i_FrameDone  (i_FrameDone),
        .o_MazeMap    (o_MazeMap),
        .o_Busy       (o_Busy),
        .o_Err        (o_Err),
        .o_CommitDone (o_CommitDone)
    );

    always #5 i_Clk = ~i_Clk;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [1199:0] exp_work = '0;
    logic [1199:0] exp_disp = '0;

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_map(input string tag, input logic [1199:0] obs, input logic [1199:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1199:0] shown();
`ifdef MAZE_DOUBLE_BUFFER_EN
        return exp_disp;
`else
        return exp_work;
`endif
    endfunction

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic wr_cell(input logic [1:0] lv, input logic [5:0] x, input logic [4:0] y, input logic wall);
        i_MazeLevel  = lv;
        wr.i_WrX     = x;
        wr.i_WrY     = y;
        wr.i_WrWall  = wall;
        wr.i_WrValid = 1'b1;
        #1;
        chk_bit("wr_ready", wr.o_WrReady, 1'b1);
        tick();
        wr.i_WrValid = 1'b0;
    endtask

    task automatic do_publish(input string tag);
        i_Commit = 1'b1;
        tick();
        i_Commit = 1'b0;
`ifdef MAZE_DOUBLE_BUFFER_EN
        chk_bit({tag, "_busy_wait"}, o_Busy, 1'b1);
        chk_bit({tag, "_done_early"}, o_CommitDone, 1'b0);
        repeat (3) tick();
        chk_map({tag, "_map_held"}, o_MazeMap, exp_disp);
        i_FrameDone = 1'b1;
        tick();
        i_FrameDone = 1'b0;
        exp_disp = exp_work;
        chk_map({tag, "_map_pub"}, o_MazeMap, exp_disp);
        chk_bit({tag, "_done"}, o_CommitDone, 1'b1);
`else
        chk_bit({tag, "_done"}, o_CommitDone, 1'b1);
        chk_bit({tag, "_busy"}, o_Busy, 1'b0);
        chk_map({tag, "_map"}, o_MazeMap, exp_work);
`endif
        tick();
        chk_bit({tag, "_done_clr"}, o_CommitDone, 1'b0);
        chk_bit({tag, "_idle"}, o_Busy, 1'b0);
    endtask

    initial begin
        int  n_busy;
        logic done_seen;

        wr.i_WrValid = 1'b0;
        wr.i_WrX     = '0;
        wr.i_WrY     = '0;
        wr.i_WrWall  = 1'b0;

        // Reset
        repeat (3) tick();
        i_Rst = 1'b1;
        tick();
        chk_map("rst_map", o_MazeMap, '0);
        chk_bit("rst_ready", wr.o_WrReady, 1'b1);
        chk_bit("rst_busy", o_Busy, 1'b0);
        chk_bit("rst_err", o_Err, 1'b0);
        chk_bit("rst_done", o_CommitDone, 1'b0);

        // Easy in-range write at (15,11) -> bit 455, then publish
        wr_cell(LV_EASY, 6'd15, 5'd11, 1'b1);
        exp_work[455] = 1'b1;
        chk_map("easy_wr_map", o_MazeMap, shown());
        chk_bit("easy_wr_err", o_Err, 1'b0);
        do_publish("pub1");
        chk_bit("pub1_bit455", o_MazeMap[455], 1'b1);

        // Out-of-range Easy write is dropped and flags the error
        wr_cell(LV_EASY, 6'd16, 5'd0, 1'b1);
        chk_bit("easy_oor_err", o_Err, 1'b1);
        chk_map("easy_oor_map", o_MazeMap, shown());

        // Hard corner cell (39,29) -> bit 1199; Normal (31,23) -> bit 951
        wr_cell(LV_HARD, 6'd39, 5'd29, 1'b1);
        exp_work[1199] = 1'b1;
        chk_map("hard_corner_map", o_MazeMap, shown());
        wr_cell(LV_NORMAL, 6'd31, 5'd23, 1'b1);
        exp_work[951] = 1'b1;
        wr_cell(LV_NORMAL, 6'd32, 5'd0, 1'b1);
        wr_cell(LV_HARD, 6'd15, 5'd11, 1'b0);
        exp_work[455] = 1'b0;
        chk_map("normal_path_map", o_MazeMap, shown());
        chk_bit("err_sticky", o_Err, 1'b1);
        do_publish("pub2");

        // A level change alone leaves stored bits untouched
        i_MazeLevel = LV_EASY;
        tick();
        chk_map("level_change_map", o_MazeMap, shown());

        // Clear with a simultaneous write: write refused, CLEAR entered
        i_Clear      = 1'b1;
        i_MazeLevel  = LV_HARD;
        wr.i_WrX     = 6'd1;
        wr.i_WrY     = 5'd0;
        wr.i_WrWall  = 1'b1;
        wr.i_WrValid = 1'b1;
        #1;
        chk_bit("clear_wr_ready", wr.o_WrReady, 1'b0);
        tick();
        i_Clear      = 1'b0;
        wr.i_WrValid = 1'b0;
        exp_work = '0;
        chk_bit("clear_busy", o_Busy, 1'b1);
        chk_bit("clear_err", o_Err, 1'b0);
        chk_bit("clear_ready", wr.o_WrReady, 1'b0);
        n_busy    = 1;
        done_seen = 1'b0;
        for (int c = 0; c < 40 && o_Busy; c++) begin
            if (c == 4) i_Commit = 1'b1;
            tick();
            i_Commit = 1'b0;
            if (o_CommitDone) done_seen = 1'b1;
            if (o_Busy) n_busy++;
        end
        chk_int("clear_cycles", n_busy, 30);
        chk_bit("clear_commit_ignored", done_seen, 1'b0);
        chk_bit("clear_end_ready", wr.o_WrReady, 1'b1);
        chk_bit("clear_end_err", o_Err, 1'b0);
        chk_map("clear_end_map", o_MazeMap, shown());
`ifdef MAZE_DOUBLE_BUFFER_EN
        do_publish("pub_clr");
`endif
        chk_map("cleared_map", o_MazeMap, '0);

        // Invalid level write is dropped
        wr_cell(2'b11, 6'd0, 5'd0, 1'b1);
        chk_bit("bad_level_err", o_Err, 1'b1);
        chk_map("bad_level_map", o_MazeMap, shown());
        wr_cell(LV_NORMAL, 6'd31, 5'd23, 1'b1);
        exp_work[951] = 1'b1;
        wr_cell(LV_EASY, 6'd0, 5'd0, 1'b1);
        exp_work[0] = 1'b1;

        // Commit coinciding with FrameDone
        i_Commit    = 1'b1;
        i_FrameDone = 1'b1;
        tick();
        i_Commit    = 1'b0;
        i_FrameDone = 1'b0;
`ifdef MAZE_DOUBLE_BUFFER_EN
        chk_bit("same_cyc_busy", o_Busy, 1'b1);
        chk_bit("same_cyc_nodone", o_CommitDone, 1'b0);
        repeat (2) tick();
        chk_map("same_cyc_held", o_MazeMap, exp_disp);
        i_FrameDone = 1'b1;
        tick();
        i_FrameDone = 1'b0;
        exp_disp = exp_work;
        chk_map("same_cyc_pub", o_MazeMap, exp_disp);
        chk_bit("same_cyc_done", o_CommitDone, 1'b1);
`else
        chk_bit("same_cyc_done", o_CommitDone, 1'b1);
        chk_bit("same_cyc_busy", o_Busy, 1'b0);
        chk_map("same_cyc_map", o_MazeMap, exp_work);
`endif
        tick();
        chk_bit("same_cyc_done_clr", o_CommitDone, 1'b0);

        // Async reset during CLEAR cycle 10
        i_Clear = 1'b1;
        tick();
        i_Clear = 1'b0;
        repeat (9) tick();
        chk_bit("mid_clear_busy", o_Busy, 1'b1);
        #1;
        i_Rst = 1'b0;
        #1;
        exp_work = '0;
        exp_disp = '0;
        chk_bit("arst_busy", o_Busy, 1'b0);
        chk_map("arst_map", o_MazeMap, '0);
        chk_bit("arst_ready", wr.o_WrReady, 1'b1);
        chk_bit("arst_err", o_Err, 1'b0);
        #1;
        i_Rst = 1'b1;
        tick();
        chk_bit("post_rst_busy", o_Busy, 1'b0);
        wr_cell(LV_HARD, 6'd39, 5'd29, 1'b1);
        exp_work[1199] = 1'b1;
        chk_map("post_rst_wr", o_MazeMap, shown());

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/maze_map_writer.md
# maze_map_writer

Write-side owner of the 40×30 maze bitmap consumed by the VGA draw path. Accepts single-cell wall writes over a valid/ready handshake, bounds-checks them against the active difficulty level, and supports bulk clear. Presents the map as a flat 1200-bit vector, with optional double buffering so the display never shows a half-built maze.

## Interface
- COLS, 40, maze columns (bit stride per row)
- ROWS, 30, maze rows
- i_Clk  in  1  system/pixel clock
- i_Rst  in  1  reset, asynchronous, active-low
- i_MazeLevel  in  2  2'b00 Easy, 2'b01 Normal, 2'b10 Hard, 2'b11 invalid
- i_Clear  in  1  pulse: zero the working map
- i_WrValid  in  1  cell write request
- o_WrReady  out  1  write accepted when i_WrValid & o_WrReady
- i_WrX  in  6  cell column
- i_WrY  in  5  cell row
- i_WrWall  in  1  value written (1 = wall, 0 = path)
- i_Commit  in  1  pulse: publish working map to display
- i_FrameDone  in  1  pulse from display at end of active region (pixel 639,479)
- o_MazeMap  out  COLS*ROWS  display map; bit index y*COLS+x
- o_Busy  out  1  high in CLEAR or WAIT_SWAP
- o_Err  out  1  sticky: out-of-range or invalid-level write seen
- o_CommitDone  out  1  one-cycle pulse when publish completes

## Operation
- States: IDLE, CLEAR, WAIT_SWAP.
- o_WrReady = (state==IDLE) & !i_Clear & !i_Commit (combinational).
- Accepted write: level limits are Easy x<16,y<12; Normal x<32,y<24; Hard x<40,y<30. In range → working bit y*40+x ← i_WrWall. Out of range or level 2'b11 → write dropped, o_Err←1.
- IDLE + i_Clear → CLEAR; row counter 0..29 zeroes one 40-bit working row per cycle; o_Err←0 on entry; after row 29 → IDLE. Priority in IDLE: i_Clear > i_Commit > write.
- IDLE + i_Commit (no i_Clear) → WAIT_SWAP (double-buffer build) or immediate publish (single-buffer).
- WAIT_SWAP: i_FrameDone → copy working to display in one cycle, pulse o_CommitDone, → IDLE. i_FrameDone is ignored in every other state, so a commit arriving in the same cycle as i_FrameDone waits for the next frame.
- i_Clear/i_Commit outside IDLE are ignored.
- i_MazeLevel is sampled per write; level changes never modify stored bits.

## Timing
- Reset state: IDLE, both buffers all-zero, o_Busy 0, o_Err 0, o_CommitDone 0, o_WrReady 1.
- Write latency: working bit updated on the edge of acceptance and visible the following cycle. o_Err is set on the same edge.
- Clear: exactly 30 cycles in CLEAR; o_WrReady low throughout; first write possible on cycle 31 after the i_Clear edge.
- Publish: o_MazeMap changes on the edge after i_FrameDone is sampled in WAIT_SWAP. o_CommitDone is high for that one cycle.
- Async reset mid-CLEAR or mid-WAIT_SWAP: returns to IDLE at once with zeroed maps; a pending commit is lost.

## Configuration
- MAZE_DOUBLE_BUFFER_EN defined: separate working and display buffers, with the WAIT_SWAP flow described above.
- MAZE_DOUBLE_BUFFER_EN undefined:
  - Single buffer; o_MazeMap is the working map, and writes and clears are visible immediately.
  - i_Commit pulses o_CommitDone on the next cycle with no state change.
  - WAIT_SWAP is unreachable and i_FrameDone is unused.

## Structure
- Shared package maze_pkg holds:
  - COLS, ROWS
  - level encodings LV_EASY/LV_NORMAL/LV_HARD
  - per-level column and row limits (16/12, 32/24, 40/30)
  - state enum
- Sub-module maze_bounds_check (combinational): inputs level, x, y; output in_range.

## Test plan
- Reset → o_MazeMap == 0, o_WrReady 1, o_Busy 0, o_Err 0.
- Easy write (15,11,1) then commit → working bit 455 set; with the macro, o_MazeMap bit 455 is still 0 until i_FrameDone, then 1 on the next cycle with o_CommitDone pulse.
- Easy write (16,0,1) → dropped, o_Err 1 next cycle, map unchanged. A Hard write (39,29,1) sets bit 1199.
- Fill several cells, then i_Clear → o_WrReady low for 30 cycles, working map 0, o_Err cleared.
- i_Commit in the same cycle as i_FrameDone → no publish; publish happens on the next i_FrameDone. i_Clear and i_WrValid together → write not accepted, CLEAR entered.
- Assert reset during CLEAR cycle 10 → IDLE, all maps 0, o_Busy 0 immediately.
